seq_detector_param: RTL and testbench
=====================================

// Module: seq_detector_param
// PURPOSE
//  Parametrised serial pattern detector; successor to the fixed 4-bit detector.
//  Pattern (1..PAT_W bits) and length are loaded at run time. Overlapping or
//  non-overlapping matching is selectable. Has input qualification and a
//  saturating match counter. Sits on a 1-bit serial stream behind the bit sampler.
// PARAMETERS
//  PAT_W   8    max pattern length in bits (>=2)
//  LEN_W   4    width of pat_len; must hold PAT_W ($clog2(PAT_W+1))
//  CNT_W   16   width of match counter
// PORTS
//  clk        in   1      system clock, all logic on posedge
//  rst        in   1      synchronous, active-high reset
//  cfg_load   in   1      1-cycle strobe: latch cfg_pat/cfg_len/cfg_ovl
//  cfg_pat    in   PAT_W  pattern; bit [cfg_len-1] is first bit on the wire, [0] last
//  cfg_len    in   LEN_W  pattern length, legal 1..PAT_W
//  cfg_ovl    in   1      1 = overlapping matches allowed, 0 = restart after match
//  din        in   1      serial data bit
//  din_vld    in   1      din is sampled only when high
//  cnt_clr    in   1      clear match_cnt
//  dout       out  1      1-cycle match pulse (registered)
//  match_cnt  out  CNT_W  saturating number of matches
//  armed      out  1      high in DETECT state
//  cfg_err    out  1      1-cycle pulse: cfg_load rejected (illegal cfg_len)
// BEHAVIOUR
//  Reset: state=IDLE, hist=0, fill=0, pattern regs=0, all outputs 0.
//  FSM: IDLE -> (legal cfg_load) FILL -> (fill==len) DETECT.
//   IDLE: din ignored; dout stays 0 until a legal pattern is loaded.
//   FILL: each din_vld shifts hist <= {hist[PAT_W-2:0],din}, fill++. On the
//     cycle the shift makes fill==len, a compare is done (same rules as DETECT), then -> DETECT.
//   DETECT: each din_vld shifts hist; match = (hist_new[len-1:0]==pat[len-1:0]).
//  dout: registered; high in the cycle after the posedge that sampled the final
//   matching bit; 0 whenever din_vld is low. Latency 1 clk.
//  On match with cfg_ovl=0: fill<=0, state->FILL (bits already used are not reused).
//   With cfg_ovl=1: history kept, state stays DETECT.
//  cfg_load legal (1<=cfg_len<=PAT_W): latch config, hist<=0, fill<=0, ->FILL,
//   dout<=0 that cycle. This holds in any state, including mid-match; din on that cycle is dropped.
//  cfg_load illegal (len 0 or >PAT_W): config/state unchanged, cfg_err pulses 1 cycle.
//  match_cnt: +1 per dout pulse; saturates at all-ones. cnt_clr has priority over increment.
//   cnt_clr and a match on the same cycle -> 0.
//  rst has priority over everything; rst mid-pattern discards partial history.
//  Unused pattern bits above len are don't-care in the compare.
//  armed = (state==DETECT).
// TESTING
//  T1 load 1001,len4,ovl1; din 1,0,0,1,0,0,1 -> dout pulses after bits 4 and 7; match_cnt=2
//  T2 same stream, ovl0 -> single pulse after bit 4; match_cnt=1
//  T3 len4 pat 1001; din 1,0,0 valid, din_vld=0 for 3 cycles (din toggling), then 1 -> one pulse
//  T4 cfg_load len1 pat 1; din 1,1,0,1 -> pulses after bits 1,2,4 (both ovl settings)
//  T5 cfg_load len=0 and len=9 (PAT_W=8) -> cfg_err pulse each; previous pattern still matches
//  T6 CNT_W=2: 5 matches -> match_cnt=3; cnt_clr with a match on the same cycle -> 0; rst after 1,0,0 then 1 -> no pulse

Source files
------------

// File: rtl/seq_detector_param.sv
// Run-time configurable serial pattern detector with overlapping/non-overlapping
// matching, input qualification and a saturating match counter.
module seq_detector_param #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pat,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_ovl,
    input  logic             din,
    input  logic             din_vld,
    input  logic             cnt_clr,
    output logic             dout,
    output logic [CNT_W-1:0] match_cnt,
    output logic             armed,
    output logic             cfg_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        DETECT = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [PAT_W-1:0] hist_r, hist_s;
    logic [PAT_W-1:0] pat_r, pat_s;
    logic [LEN_W-1:0] len_r, len_s;
    logic [LEN_W-1:0] fill_r, fill_s;
    logic             ovl_r, ovl_s;
    logic             dout_r, dout_s;
    logic             err_r, err_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [PAT_W-1:0] shift_s;
    logic [LEN_W-1:0] fill_inc_s;
    logic             cfg_ok_s;
    logic             hit_s;

    // Only the low n bits take part; pattern bits above the length are don't-care.
    function automatic logic tail_match(input logic [PAT_W-1:0] h,
                                        input logic [PAT_W-1:0] p,
                                        input logic [LEN_W-1:0] n);
        logic [PAT_W-1:0] m;
        for (int i = 0; i < PAT_W; i++) begin
            m[i] = (LEN_W'(i) < n);
        end
        return (((h ^ p) & m) == {PAT_W{1'b0}});
    endfunction

    // Next-state, datapath and output decode
    always_comb begin
        state_s    = state_r;
        hist_s     = hist_r;
        pat_s      = pat_r;
        len_s      = len_r;
        fill_s     = fill_r;
        ovl_s      = ovl_r;
        dout_s     = 1'b0;
        err_s      = 1'b0;
        shift_s    = {hist_r[PAT_W-2:0], din};
        fill_inc_s = fill_r + LEN_W'(1);
        cfg_ok_s   = (cfg_len != {LEN_W{1'b0}}) && (cfg_len <= LEN_W'(PAT_W));
        hit_s      = tail_match(shift_s, pat_r, len_r);

        if (cfg_load && cfg_ok_s) begin
            // A legal load wins over the data path; that cycle's din is dropped.
            pat_s   = cfg_pat;
            len_s   = cfg_len;
            ovl_s   = cfg_ovl;
            hist_s  = {PAT_W{1'b0}};
            fill_s  = {LEN_W{1'b0}};
            state_s = FILL;
        end else begin
            err_s = cfg_load;
            case (state_r)
                IDLE: begin
                    state_s = IDLE;
                end
                FILL: begin
                    if (din_vld) begin
                        hist_s = shift_s;
                        fill_s = fill_inc_s;
                        if (fill_inc_s == len_r) begin
                            dout_s = hit_s;
                            if (hit_s && !ovl_r) begin
                                fill_s  = {LEN_W{1'b0}};
                                state_s = FILL;
                            end else begin
                                state_s = DETECT;
                            end
                        end else begin
                            state_s = FILL;
                        end
                    end else begin
                        state_s = FILL;
                    end
                end
                DETECT: begin
                    if (din_vld) begin
                        hist_s = shift_s;
                        dout_s = hit_s;
                        if (hit_s && !ovl_r) begin
                            fill_s  = {LEN_W{1'b0}};
                            state_s = FILL;
                        end else begin
                            state_s = DETECT;
                        end
                    end else begin
                        state_s = DETECT;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end

        if (cnt_clr) begin
            cnt_s = {CNT_W{1'b0}};
        end else if (dout_s && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_s = cnt_r + CNT_W'(1);
        end else begin
            cnt_s = cnt_r;
        end
    end

    // State, history, configuration and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            hist_r  <= {PAT_W{1'b0}};
            pat_r   <= {PAT_W{1'b0}};
            len_r   <= {LEN_W{1'b0}};
            fill_r  <= {LEN_W{1'b0}};
            ovl_r   <= 1'b0;
            dout_r  <= 1'b0;
            err_r   <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            hist_r  <= hist_s;
            pat_r   <= pat_s;
            len_r   <= len_s;
            fill_r  <= fill_s;
            ovl_r   <= ovl_s;
            dout_r  <= dout_s;
            err_r   <= err_s;
            cnt_r   <= cnt_s;
        end
    end

    assign dout      = dout_r;
    assign match_cnt = cnt_r;
    assign armed     = (state_r == DETECT);
    assign cfg_err   = err_r;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed vector table, then random traffic
// against a queue-based reference model; two instances (16-bit and 2-bit counter).
module tb_seq_detector_param;
    localparam int PAT_W = 8;
    localparam int LEN_W = 4;

    logic clk = 1'b0;
    logic rst, cfg_load, cfg_ovl, din, din_vld, cnt_clr;
    logic [PAT_W-1:0] cfg_pat;
    logic [LEN_W-1:0] cfg_len;
    logic dout_a, armed_a, err_a, dout_b, armed_b, err_b;
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_detector_param #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
        .cfg_ovl(cfg_ovl), .din(din), .din_vld(din_vld), .cnt_clr(cnt_clr),
        .dout(dout_a), .match_cnt(cnt_a), .armed(armed_a), .cfg_err(err_a));

    seq_detector_param #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
        .cfg_ovl(cfg_ovl), .din(din), .din_vld(din_vld), .cnt_clr(cnt_clr),
        .dout(dout_b), .match_cnt(cnt_b), .armed(armed_b), .cfg_err(err_b));

    // Reference model: bits received since the last (re)start, newest at the back.
    bit         mq[$];
    bit         mcfg, movl, mdout, merr;
    bit [7:0]   mpat;
    int         mlen, mcnt, mcnt2;

    function automatic bit tail_matches();
        for (int k = 0; k < mlen; k++) begin
            if (mq[mq.size() - 1 - k] != mpat[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_step();
        bit legal;
        legal = (cfg_len >= 4'd1) && (cfg_len <= 4'd8);
        if (rst) begin
            mq.delete();
            mcfg = 1'b0; movl = 1'b0; mpat = 8'h00; mlen = 0;
            mdout = 1'b0; merr = 1'b0; mcnt = 0; mcnt2 = 0;
            return;
        end
        mdout = 1'b0;
        merr  = 1'b0;
        if (cfg_load && legal) begin
            mpat = cfg_pat; mlen = int'(cfg_len); movl = cfg_ovl; mcfg = 1'b1;
            mq.delete();
        end else begin
            merr = cfg_load;
            if (mcfg && din_vld) begin
                mq.push_back(din);
                if (mq.size() > PAT_W) void'(mq.pop_front());
                if (mq.size() >= mlen && tail_matches()) begin
                    mdout = 1'b1;
                    if (!movl) mq.delete();
                end
            end
        end
        if (cnt_clr) begin
            mcnt = 0; mcnt2 = 0;
        end else if (mdout) begin
            if (mcnt < 65535) mcnt++;
            if (mcnt2 < 3) mcnt2++;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic cycle(input bit r, input bit ld, input bit [7:0] p, input bit [3:0] l,
                         input bit o, input bit d, input bit v, input bit c);
        bit exp_armed;
        rst = r; cfg_load = ld; cfg_pat = p; cfg_len = l; cfg_ovl = o;
        din = d; din_vld = v; cnt_clr = c;
        @(posedge clk);
        model_step();
        #1;
        exp_armed = mcfg && (mq.size() >= mlen);
        chk("dout_a",  {31'd0, dout_a},  {31'd0, mdout});
        chk("dout_b",  {31'd0, dout_b},  {31'd0, mdout});
        chk("cnt_a",   {16'd0, cnt_a},   mcnt);
        chk("cnt_b",   {30'd0, cnt_b},   mcnt2);
        chk("armed_a", {31'd0, armed_a}, {31'd0, exp_armed});
        chk("armed_b", {31'd0, armed_b}, {31'd0, exp_armed});
        chk("cfg_err", {31'd0, err_a},   {31'd0, merr});
    endtask

    typedef struct {
        bit       r, ld;
        bit [7:0] pat;
        bit [3:0] len;
        bit       ovl, din, vld, clr;
        bit       e_dout, e_armed, e_err;
        bit [1:0] e_cnt2;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t dv(input bit d, input bit v, input bit c,
                                input bit ed, input bit ea, input bit [1:0] ec);
        return '{1'b0, 1'b0, 8'h00, 4'd0, 1'b0, d, v, c, ed, ea, 1'b0, ec};
    endfunction

    function automatic vec_t lv(input bit [7:0] p, input bit [3:0] l, input bit o,
                                input bit ea, input bit ee, input bit [1:0] ec);
        return '{1'b0, 1'b1, p, l, o, 1'b0, 1'b0, 1'b0, 1'b0, ea, ee, ec};
    endfunction

    initial begin
        bit [3:0] rl;
        bit       rld;
        // Reset, then T1: 1001 overlapping
        tbl.push_back('{1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0});
        tbl.push_back(lv(8'h09, 4'd4, 1'b1, 1'b0, 1'b0, 2'd0));
        tbl.push_back(dv(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0));
        tbl.push_back(dv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0));
        tbl.push_back(dv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0));
        tbl.push_back(dv(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1));
        tbl.push_back(dv(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1));
        tbl.push_back(dv(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1));
        tbl.push_back(dv(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2));
        // T2: same stream, non-overlapping
        tbl.push_back(lv(8'h09, 4'd4, 1'b0, 1'b0, 1'b0, 2'd2));
        tbl.push_back(dv(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2));
        tbl.push_back(dv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2));
        tbl.push_back(dv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2));
        tbl.push_back(dv(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd3));
        tbl.push_back(dv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3));
        tbl.push_back(dv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3));
        tbl.push_back(dv(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3));
        // T3: gaps in din_vld with din toggling
        tbl.push_back(lv(8'h09, 4'd4, 1'b1, 1'b0, 1'b0, 2'd3));
        tbl.push_back(dv(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3));
        tbl.push_back(dv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3));
        tbl.push_back(dv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3));
        tbl.push_back(dv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3));
        tbl.push_back(dv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3));
        tbl.push_back(dv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3));
        tbl.push_back(dv(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd3));
        // T4: length-1 pattern, non-overlapping then overlapping
        tbl.push_back(lv(8'h01, 4'd1, 1'b0, 1'b0, 1'b0, 2'd3));
        tbl.push_back(dv(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd3));
        tbl.push_back(dv(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd3));
        tbl.push_back(dv(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3));
        tbl.push_back(dv(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd3));
        tbl.push_back(lv(8'h01, 4'd1, 1'b1, 1'b0, 1'b0, 2'd3));
        tbl.push_back(dv(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd3));
        tbl.push_back(dv(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd3));
        tbl.push_back(dv(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3));
        tbl.push_back(dv(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd3));
        // T5: illegal lengths rejected, old pattern kept
        tbl.push_back(lv(8'hFF, 4'd0, 1'b0, 1'b1, 1'b1, 2'd3));
        tbl.push_back(lv(8'h00, 4'd9, 1'b0, 1'b1, 1'b1, 2'd3));
        tbl.push_back(dv(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd3));
        // T6: clear beats a same-cycle match; reset mid-pattern drops history
        tbl.push_back(dv(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0));
        tbl.push_back(dv(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1));
        tbl.push_back(lv(8'h09, 4'd4, 1'b1, 1'b0, 1'b0, 2'd1));
        tbl.push_back(dv(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1));
        tbl.push_back(dv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1));
        tbl.push_back(dv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1));
        tbl.push_back('{1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0});
        tbl.push_back(dv(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0));

        rst = 1'b1; cfg_load = 1'b0; cfg_pat = 8'h00; cfg_len = 4'd0; cfg_ovl = 1'b0;
        din = 1'b0; din_vld = 1'b0; cnt_clr = 1'b0;
        @(negedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].r, tbl[i].ld, tbl[i].pat, tbl[i].len, tbl[i].ovl,
                  tbl[i].din, tbl[i].vld, tbl[i].clr);
            chk($sformatf("tbl%0d_dout", i),  {31'd0, dout_a},  {31'd0, tbl[i].e_dout});
            chk($sformatf("tbl%0d_armed", i), {31'd0, armed_a}, {31'd0, tbl[i].e_armed});
            chk($sformatf("tbl%0d_err", i),   {31'd0, err_b},   {31'd0, tbl[i].e_err});
            chk($sformatf("tbl%0d_cnt2", i),  {30'd0, cnt_b},   {30'd0, tbl[i].e_cnt2});
        end

        // Random traffic: short patterns mostly, occasional illegal loads, clears and resets
        for (int n = 0; n < 4000; n++) begin
            rld = ($urandom_range(0, 29) == 0);
            rl  = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 10)) : 4'($urandom_range(1, 3));
            cycle(($urandom_range(0, 299) == 0), rld, 8'($urandom), rl, 1'($urandom),
                  1'($urandom),
                  (rld && (rl == 4'd0 || rl > 4'd8)) ? 1'b0 : ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 99) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
